// File: rtl/ifns_decoder_seq_if.sv
// Handshake bundle for the bit-serial IFNS decoder: codeword in, decoded value out.
interface ifns_decoder_seq_if #(
   parameter int unsigned CW_W   = 33,
   parameter int unsigned DATA_W = 23
);
   logic              in_valid;
   logic              in_ready;
   logic [CW_W-1:0]   cw;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] v;
   logic              ovf;

   modport master (
      output in_valid, cw, out_ready,
      input  in_ready, out_valid, v, ovf
   );

   modport slave (
      input  in_valid, cw, out_ready,
      output in_ready, out_valid, v, ovf
   );
endinterface

// File: rtl/ifns_decoder_seq.sv
// Bit-serial IFNS (Fibonacci-weighted) codeword decoder, LSB first, one bit per cycle.
// Optional IFNS_DEC_EARLY_EXIT_EN: leave RUN as soon as no set bits remain in the codeword.
module ifns_decoder_seq (
   input  logic               clk,
   input  logic               rst,
   ifns_decoder_seq_if.slave  bus
);
   localparam int unsigned CW_W    = 33;
   localparam int unsigned DATA_W  = 23;
   localparam logic [23:0] W_TOP   = 24'd5702887;
   localparam logic [23:0] OVF_LIM = 24'd8388608;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state;
   logic [CW_W-1:0]   sh;
   logic [23:0]       acc;
   logic [23:0]       fa;
   logic [23:0]       fb;
   logic [5:0]        cnt;
   logic              in_ready_r;
   logic              out_valid_r;
   logic [DATA_W-1:0] v_r;
   logic              ovf_r;

   logic [23:0]       w;
   logic [23:0]       acc_nxt;
   logic              last;

   always_comb begin
      // The top bit carries a fixed weight instead of continuing the Fibonacci run.
      w       = (cnt == 6'd32) ? W_TOP : fa;
      acc_nxt = sh[0] ? (acc + w) : acc;
`ifdef IFNS_DEC_EARLY_EXIT_EN
      last    = (cnt == 6'd32) || ((sh >> 1) == '0);
`else
      last    = (cnt == 6'd32);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StIdle;
         sh          <= '0;
         acc         <= '0;
         fa          <= 24'd1;
         fb          <= 24'd1;
         cnt         <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         v_r         <= '0;
         ovf_r       <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (bus.in_valid) begin
                  sh         <= bus.cw;
                  acc        <= '0;
                  fa         <= 24'd1;
                  fb         <= 24'd1;
                  cnt        <= '0;
                  in_ready_r <= 1'b0;
                  state      <= StRun;
               end
            end
            StRun: begin
               acc <= acc_nxt;
               sh  <= sh >> 1;
               fa  <= fb;
               fb  <= fa + fb;
               cnt <= cnt + 6'd1;
               if (last) begin
                  state       <= StDone;
                  out_valid_r <= 1'b1;
                  v_r         <= acc_nxt[DATA_W-1:0];
                  ovf_r       <= (acc_nxt >= OVF_LIM);
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  state       <= StIdle;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.v         = v_r;
   assign bus.ovf       = ovf_r;
endmodule
